// File: rtl/mem_responder_if.sv
// Request/response bundle between the MAR/MDR side and the memory responder.
// The requester holds a strobe until Ready, then drops it.
interface mem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              Ready;
    logic              Busy;
    logic              err;

    modport master (
        output Read, Write, addr, wdata,
        input  rdata, Ready, Busy, err
    );

    modport slave (
        input  Read, Write, addr, wdata,
        output rdata, Ready, Busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder: latches one request, inserts wait states,
// performs the access and pulses Ready for one cycle.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            clr,
    mem_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_RELEASE
    } state_e;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q;
    logic              req_one;
    logic              req_any;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req_one = bus.Read ^ bus.Write;
    assign req_any = bus.Read | bus.Write;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            if (state_q == S_ACCESS && !wr_q)
                rdata_q <= mem[addr_q];
        end
    end

    // RAM has no reset; reset forces IDLE, so an aborted write never lands
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && wr_q)
            mem[addr_q] <= wdata_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (req_one) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    wr_d    = bus.Write;
                    cnt_d   = WS;
                    state_d = (WS != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = S_ACCESS;
            end
            S_ACCESS:  state_d = S_DONE;
            S_DONE:    state_d = req_any ? S_RELEASE : S_IDLE;
            S_RELEASE: if (!req_any) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Ready = (state_q == S_DONE);
        bus.Busy  = (state_q != S_IDLE);
        bus.err   = (state_q == S_IDLE) && bus.Read && bus.Write;
        bus.rdata = rdata_q;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the bus datapath. It accepts word read/write requests driven from the MAR/MDR side, inserts a fixed number of wait states, performs the access on an internal word-addressed RAM and signals completion with a one-cycle `Ready` pulse. Read data returns on `rdata`, which feeds the MDR's `MDatain` input. Requests use a level handshake: the requester holds its strobe until `Ready` is seen and then drops it before issuing the next request.

## Interface
- `ADDR_W`, default 9: word-address width; the RAM depth is 2^ADDR_W words.
- `DATA_W`, default 32: word width; must equal the bus width.
- `WAIT_STATES`, default 2: number of wait cycles inserted before the access; legal range 0–15.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `clr`  in  1: reset; asynchronous, active-low.
- `Read`  in  1: read request level.
- `Write`  in  1: write request level.
- `addr`  in  ADDR_W: word address, from MAR bits [ADDR_W-1:0].
- `wdata`  in  DATA_W: write data, from MDR.
- `rdata`  out  DATA_W: read data, to MDR `MDatain`.
- `Ready`  out  1: access complete; one-cycle pulse.
- `Busy`  out  1: a request is in progress (state ≠ IDLE).
- `err`  out  1: in IDLE with `Read` and `Write` both high.

## Operation
- States: IDLE, WAIT, ACCESS, DONE, RELEASE.
- **IDLE**
  - Exactly one of `Read`/`Write` high: latch `addr`, `wdata` and the operation type.
  - Load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise ACCESS.
  - Both strobes high: no acceptance; `err`=1 (combinational, IDLE only); stay in IDLE.
- **WAIT**: decrement the counter each cycle; go to ACCESS when the counter reaches 1.
- **ACCESS**, one cycle, on its closing edge:
  - Write: `mem[addr_latched] <= wdata_latched`; `rdata` unchanged.
  - Read: `rdata <= mem[addr_latched]`.
  - Next state is DONE.
- **DONE**: `Ready`=1 for exactly this cycle. Next state is RELEASE if either strobe is still high, otherwise IDLE.
- **RELEASE**: wait until `Read`=`Write`=0, then go to IDLE. No new request is accepted before that.
- Request capture rules:
  - Inputs are latched at acceptance; changes to `addr`/`wdata`/strobes during WAIT or ACCESS are ignored.
  - Dropping a strobe mid-request does not cancel it; the access still completes.
- `rdata` holds the last read value until the next read completes, including across writes.
- Addresses are exactly ADDR_W bits; there is no out-of-range case. The top address is 2^ADDR_W-1, and the RAM does not wrap beyond it.
- RAM contents are undefined at power-up and are not affected by `clr`.

## Timing
- Reset (`clr`=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - `Ready`=0, `Busy`=0, `rdata`=0, `err` follows the strobes.
  - A pending write whose ACCESS edge has not occurred is aborted; memory is not written.
- Release is synchronous: the first rising edge with `clr`=1 may accept a request.
- Latency, with the request accepted at edge k:
  - ACCESS completes at edge k+WAIT_STATES+1.
  - `Ready` is high from that edge to the next one.
  - With WAIT_STATES=2: accepted at edge 1, `Ready` high during the cycle after edge 4.
- `Ready` and `Busy` are registered state decodes; `err` is combinational.
- Minimum request spacing:
  - If the requester drops its strobe in the `Ready` cycle, the next request is accepted at edge k+WAIT_STATES+3.
  - Otherwise RELEASE adds one cycle or more.
- `Busy` is high from the accepting edge until the return to IDLE.

## Test plan
- **Write then read**, WAIT_STATES=2: Write `addr`=5, `wdata`=32'hDEADBEEF; hold until `Ready`, drop; then Read `addr`=5.
  - Required: each `Ready` arrives 3 cycles after acceptance, and `rdata`=32'hDEADBEEF is valid in the read's `Ready` cycle.
- **Address boundaries**: write 32'h1 to addr 0 and 32'h2 to addr 511, then read both back.
  - Required: `rdata`=1 and 2 respectively; there is no aliasing between the two addresses.
- **Simultaneous strobes**: `Read`=`Write`=1 in IDLE for 3 cycles.
  - Required: `err`=1, `Busy`=0, no `Ready`, memory unchanged.
  - Then drop `Write`: the read is accepted at the next edge.
- **Reset mid-request**: Write addr 7 = 32'hA5A5A5A5 over old value 32'h0; pull `clr` low during WAIT.
  - Required: `Busy`=0, `Ready`=0 and `rdata`=0 immediately; a later read of addr 7 returns 32'h0.
- **Strobe held and inputs changed**:
  - Holding `Read` after `Ready` keeps the state in RELEASE with no second `Ready`.
  - Changing `addr` during WAIT does not change the returned data.
- **WAIT_STATES=0**: read accepted at edge k → `Ready` high after edge k+1; back-to-back reads to addrs 3 and 4 return the correct words.
